adder_pipe_nb: RTL

//  Parametrised, pipelined unsigned adder. Successor to the fixed 128b combinational adder.

---
 rtl/adder_pipe_nb.sv | 103 ++++++++++
 1 files changed

// File: rtl/adder_pipe_nb.sv
// adder_pipe_nb: pipelined unsigned WIDTH-bit adder with a valid/ready handshake.
// The add is split into STAGES carry-chained segments of SEG = WIDTH/STAGES bits,
// with one segment resolved per pipeline stage. A single global advance signal
// stalls the whole pipe when the sink back-pressures.
// Optional feature macro: ADDER_SAT_EN -- when defined, the final stage saturates
// out0 to all ones whenever the full carry-out is set (out1 still reports it).
module adder_pipe_nb #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out1
);

  localparam int unsigned SEG = (STAGES > 0) ? (WIDTH / STAGES) : WIDTH;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("adder_pipe_nb: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  // Per-stage registers. Operand registers hold the not-yet-added high slices,
  // shifted down so the next stage always finds its slice at [SEG-1:0].
  // Sum registers keep finished slices at their final bit positions.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  // Stage inputs (from the ports for stage 0, else from the previous stage).
  logic             v_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];
  logic [SEG:0]     seg_sum [STAGES];

  logic advance;

  assign out_valid = v_q[STAGES-1];
  assign out1      = c_q[STAGES-1];
  assign out0      = s_q[STAGES-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;

  // Route stage inputs and compute each stage's segment add with carry-in.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        v_in[k] = in_valid & in_ready;
        c_in[k] = 1'b0;
        a_in[k] = in0;
        b_in[k] = in1;
        s_in[k] = '0;
      end else begin
        v_in[k] = v_q[k-1];
        c_in[k] = c_q[k-1];
        a_in[k] = a_q[k-1];
        b_in[k] = b_q[k-1];
        s_in[k] = s_q[k-1];
      end
      seg_sum[k] = {1'b0, a_in[k][SEG-1:0]} + {1'b0, b_in[k][SEG-1:0]}
                 + {{SEG{1'b0}}, c_in[k]};
    end
  end

  // Shift every stage forward on advance; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= seg_sum[k][SEG];
        a_q[k] <= a_in[k] >> SEG;
        b_q[k] <= b_in[k] >> SEG;
        s_q[k] <= s_in[k] | (WIDTH'(seg_sum[k][SEG-1:0]) << (k * SEG));
      end
`ifdef ADDER_SAT_EN
      // Overrides the modular sum written above when the full add overflows.
      if (seg_sum[STAGES-1][SEG]) begin
        s_q[STAGES-1] <= '1;
      end
`else
`endif
    end
  end

endmodule
